// File: rtl/seven_seg_text_scanner.sv
// Multiplexed 7-segment text scanner: message buffer, one-hot digit scan and window scrolling.
// Optional per-slot segment dimming is enabled by defining SEVEN_SEG_DIM_EN.
module seven_seg_text_scanner #(
    parameter int unsigned N_DIGITS      = 8,
    parameter int unsigned MSG_LEN       = 16,
    parameter int unsigned DIV_CYCLES    = 4096,
    parameter int unsigned SCROLL_FRAMES = 64
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       wr_en,
    input  logic [$clog2(MSG_LEN)-1:0] wr_addr,
    input  logic [4:0]                 wr_char,
    input  logic                       wr_dp,
    input  logic                       scroll_en,
    input  logic                       scroll_clr,
`ifdef SEVEN_SEG_DIM_EN
    input  logic [3:0]                 brightness,
`endif
    output logic [7:0]                 abcdefgh,
    output logic [N_DIGITS-1:0]        digit,
    output logic                       frame_tick
);

    localparam int unsigned AW = $clog2(MSG_LEN);
    localparam int unsigned SW = AW + 1;
    localparam int unsigned CW = $clog2(DIV_CYCLES);
    localparam int unsigned DW = $clog2(N_DIGITS);
    localparam int unsigned FW = (SCROLL_FRAMES > 1) ? $clog2(SCROLL_FRAMES) : 1;

    // Segment pattern {a,b,c,d,e,f,g}; the decimal point is appended separately.
    function automatic logic [6:0] seg_decode(input logic [4:0] code);
        logic [6:0] seg;
        case (code)
            5'h00:   seg = 7'b111_1110;
            5'h01:   seg = 7'b011_0000;
            5'h02:   seg = 7'b110_1101;
            5'h03:   seg = 7'b111_1001;
            5'h04:   seg = 7'b011_0011;
            5'h05:   seg = 7'b101_1011;
            5'h06:   seg = 7'b101_1111;
            5'h07:   seg = 7'b111_0000;
            5'h08:   seg = 7'b111_1111;
            5'h09:   seg = 7'b111_1011;
            5'h0A:   seg = 7'b111_0111;
            5'h0B:   seg = 7'b001_1111;
            5'h0C:   seg = 7'b100_1110;
            5'h0D:   seg = 7'b011_1101;
            5'h0E:   seg = 7'b100_1111;
            5'h0F:   seg = 7'b100_0111;
            5'h11:   seg = 7'b110_0111;
            5'h12:   seg = 7'b101_1110;
            5'h13:   seg = 7'b000_1110;
            5'h14:   seg = 7'b011_0111;
            5'h15:   seg = 7'b011_1110;
            5'h16:   seg = 7'b000_0001;
            default: seg = 7'b000_0000;
        endcase
        return seg;
    endfunction

    // Message buffer
    logic [MSG_LEN-1:0][4:0] char_q;
    logic [MSG_LEN-1:0]      dp_q;
    logic                    addr_ok;

    // Scan and scroll state
    logic [CW-1:0]       scan_cnt_q, scan_cnt_d;
    logic [N_DIGITS-1:0] digit_q, digit_d;
    logic [DW-1:0]       idx_q, idx_d, idx_next;
    logic [7:0]          seg_q, seg_d, seg_new;
    logic                frame_tick_q, frame_tick_d;
    logic [AW-1:0]       offset_q, offset_d;
    logic [FW-1:0]       frame_cnt_q, frame_cnt_d;
    logic                advance;
    logic [SW-1:0]       sel_sum;
    logic [AW-1:0]       sel_idx;

    // Address width may exceed MSG_LEN when it is not a power of two.
    assign addr_ok = ({1'b0, wr_addr} < SW'(MSG_LEN));

    always_ff @(posedge clock) begin
        if (reset) begin
            char_q <= {MSG_LEN{5'h10}};
            dp_q   <= '0;
        end else if (wr_en && addr_ok) begin
            char_q[wr_addr] <= wr_char;
            dp_q[wr_addr]   <= wr_dp;
        end
    end

    assign advance = (scan_cnt_q == CW'(DIV_CYCLES - 1));

    // Entry for the digit about to light: leftmost digit shows the entry at offset.
    always_comb begin
        idx_next = (idx_q == DW'(N_DIGITS - 1)) ? '0 : idx_q + DW'(1);
        sel_sum  = SW'(offset_q) + SW'(N_DIGITS - 1) - SW'(idx_next);
        if (sel_sum >= SW'(MSG_LEN)) begin
            sel_idx = AW'(sel_sum - SW'(MSG_LEN));
        end else begin
            sel_idx = AW'(sel_sum);
        end
        seg_new = {seg_decode(char_q[sel_idx]), dp_q[sel_idx]};
    end

    always_comb begin
        scan_cnt_d   = scan_cnt_q + CW'(1);
        digit_d      = digit_q;
        idx_d        = idx_q;
        seg_d        = seg_q;
        frame_tick_d = 1'b0;
        if (advance) begin
            scan_cnt_d   = '0;
            digit_d      = {digit_q[N_DIGITS-2:0], digit_q[N_DIGITS-1]};
            idx_d        = idx_next;
            seg_d        = seg_new;
            frame_tick_d = digit_q[N_DIGITS-1];
        end
    end

    // A clear overrides any scroll step landing in the same cycle.
    always_comb begin
        offset_d    = offset_q;
        frame_cnt_d = frame_cnt_q;
        if (scroll_clr) begin
            offset_d    = '0;
            frame_cnt_d = '0;
        end else if (scroll_en && frame_tick_q) begin
            if (frame_cnt_q == FW'(SCROLL_FRAMES - 1)) begin
                frame_cnt_d = '0;
                offset_d    = (offset_q == AW'(MSG_LEN - 1)) ? '0 : offset_q + AW'(1);
            end else begin
                frame_cnt_d = frame_cnt_q + FW'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            scan_cnt_q   <= '0;
            digit_q      <= N_DIGITS'(1);
            idx_q        <= '0;
            seg_q        <= '0;
            frame_tick_q <= 1'b0;
            offset_q     <= '0;
            frame_cnt_q  <= '0;
        end else begin
            scan_cnt_q   <= scan_cnt_d;
            digit_q      <= digit_d;
            idx_q        <= idx_d;
            seg_q        <= seg_d;
            frame_tick_q <= frame_tick_d;
            offset_q     <= offset_d;
            frame_cnt_q  <= frame_cnt_d;
        end
    end

`ifdef SEVEN_SEG_DIM_EN
    logic [CW+4:0] dim_prod;
    logic [CW:0]   on_next, on_q, on_d;
    logic [7:0]    out_q, out_d;

    // Lit cycles per slot: (brightness+1)*DIV_CYCLES/16, latched when the slot starts.
    always_comb begin
        dim_prod = ((CW+5)'(brightness) + (CW+5)'(1)) * (CW+5)'(DIV_CYCLES);
        on_next  = (CW+1)'(dim_prod >> 4);
        on_d     = on_q;
        out_d    = 8'h00;
        if (advance) begin
            on_d = on_next;
            if (on_next != '0) begin
                out_d = seg_new;
            end
        end else if (({1'b0, scan_cnt_q} + (CW+1)'(1)) < on_q) begin
            out_d = seg_q;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            on_q  <= '0;
            out_q <= '0;
        end else begin
            on_q  <= on_d;
            out_q <= out_d;
        end
    end

    assign abcdefgh = out_q;
`else
    assign abcdefgh = seg_q;
`endif

    assign digit      = digit_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seven_seg_text_scanner.sv
// Directed table-driven bench for seven_seg_text_scanner (4 digits, 8 entries, 4-cycle slots).
// A second 6-entry instance exercises out-of-range buffer writes.
module tb_seven_seg_text_scanner;

    logic       clock = 1'b0;
    logic       reset;
    logic       wr_en, wr_en_b;
    logic [2:0] wr_addr;
    logic [4:0] wr_char;
    logic       wr_dp;
    logic       scroll_en, scroll_clr;
    logic [7:0] abcdefgh, abcdefgh_b;
    logic [3:0] digit, digit_b;
    logic       frame_tick, frame_tick_b;
`ifdef SEVEN_SEG_DIM_EN
    logic [3:0] brightness = 4'hF;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    seven_seg_text_scanner #(
        .N_DIGITS(4), .MSG_LEN(8), .DIV_CYCLES(4), .SCROLL_FRAMES(2)
    ) dut (
        .clock(clock), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_char(wr_char), .wr_dp(wr_dp), .scroll_en(scroll_en), .scroll_clr(scroll_clr),
`ifdef SEVEN_SEG_DIM_EN
        .brightness(brightness),
`endif
        .abcdefgh(abcdefgh), .digit(digit), .frame_tick(frame_tick)
    );

    seven_seg_text_scanner #(
        .N_DIGITS(4), .MSG_LEN(6), .DIV_CYCLES(4), .SCROLL_FRAMES(2)
    ) dut_b (
        .clock(clock), .reset(reset), .wr_en(wr_en_b), .wr_addr(wr_addr),
        .wr_char(wr_char), .wr_dp(wr_dp), .scroll_en(1'b0), .scroll_clr(1'b0),
`ifdef SEVEN_SEG_DIM_EN
        .brightness(brightness),
`endif
        .abcdefgh(abcdefgh_b), .digit(digit_b), .frame_tick(frame_tick_b)
    );

    typedef struct {
        logic        wr_en;
        logic [2:0]  addr;
        logic [4:0]  ch;
        logic        dp;
        logic        sen;
        logic        sclr;
        int unsigned wait_cyc;
        logic [3:0]  exp_digit;
        logic [7:0]  exp_seg;
        logic        exp_ft;
    } vec_t;

    vec_t vq[$];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic we, input logic [2:0] a, input logic [4:0] c, input logic d,
                       input logic se, input logic sc, input int unsigned w,
                       input logic [3:0] ed, input logic [7:0] es, input logic ef);
        vec_t v;
        v.wr_en = we; v.addr = a; v.ch = c; v.dp = d; v.sen = se; v.sclr = sc;
        v.wait_cyc = w; v.exp_digit = ed; v.exp_seg = es; v.exp_ft = ef;
        vq.push_back(v);
    endtask

    initial begin
        // Comments give the cycle count since reset release at which each check lands.
        add(0, 0, 5'h00, 0, 0, 0,   0, 4'b0001, 8'h00, 0); // 0 reset state
        add(0, 0, 5'h00, 0, 0, 0,   3, 4'b0001, 8'h00, 0); // 3
        add(0, 0, 5'h00, 0, 0, 0,   1, 4'b0010, 8'h00, 0); // 4
        add(0, 0, 5'h00, 0, 0, 0,   4, 4'b0100, 8'h00, 0); // 8
        add(0, 0, 5'h00, 0, 0, 0,   8, 4'b0001, 8'h00, 1); // 16 frame tick
        add(0, 0, 5'h00, 0, 0, 0,   1, 4'b0001, 8'h00, 0); // 17
        add(1, 0, 5'h0F, 0, 0, 0,   1, 4'b0001, 8'h00, 0); // 18 F
        add(1, 1, 5'h11, 0, 0, 0,   1, 4'b0001, 8'h00, 0); // 19 P
        add(1, 2, 5'h12, 0, 0, 0,   1, 4'b0010, 8'h00, 0); // 20 G written on advance edge
        add(1, 3, 5'h0A, 0, 0, 0,   1, 4'b0010, 8'h00, 0); // 21 A
        add(0, 0, 5'h00, 0, 0, 0,   3, 4'b0100, 8'hCE, 0); // 24
        add(0, 0, 5'h00, 0, 0, 0,   4, 4'b1000, 8'h8E, 0); // 28
        add(0, 0, 5'h00, 0, 0, 0,   4, 4'b0001, 8'hEE, 1); // 32
        add(0, 0, 5'h00, 0, 0, 0,   4, 4'b0010, 8'hBC, 0); // 36
        add(1, 2, 5'h12, 1, 0, 0,   1, 4'b0010, 8'hBC, 0); // 37 G with dp
        add(0, 0, 5'h00, 0, 0, 0,  15, 4'b0010, 8'hBD, 0); // 52
        add(1, 2, 5'h12, 0, 0, 0,   1, 4'b0010, 8'hBD, 0); // 53 restore G
        add(1, 4, 5'h16, 0, 0, 0,   1, 4'b0010, 8'hBD, 0); // 54 '-'
        add(0, 0, 5'h00, 0, 1, 0,  38, 4'b1000, 8'hCE, 0); // 92 offset 1
        add(0, 0, 5'h00, 0, 1, 0,   4, 4'b0001, 8'h02, 1); // 96
        add(0, 0, 5'h00, 0, 1, 0, 192, 4'b0001, 8'hBC, 1); // 288 offset 7 wraps
        add(0, 0, 5'h00, 0, 1, 0,  28, 4'b1000, 8'h8E, 0); // 316 offset back to 0
        add(0, 0, 5'h00, 0, 1, 0,   4, 4'b0001, 8'hEE, 1); // 320
        add(0, 0, 5'h00, 0, 1, 0,  16, 4'b0001, 8'hEE, 1); // 336 step due now
        add(0, 0, 5'h00, 0, 1, 1,   1, 4'b0001, 8'hEE, 0); // 337 clear beats step
        add(0, 0, 5'h00, 0, 0, 0,  11, 4'b1000, 8'h8E, 0); // 348
        add(0, 0, 5'h00, 0, 0, 0,  64, 4'b1000, 8'h8E, 0); // 412 held
        add(0, 0, 5'h00, 0, 1, 0,  30, 4'b0100, 8'hBC, 0); // 442 offset 1
        add(0, 0, 5'h00, 0, 1, 1,   1, 4'b0100, 8'hBC, 0); // 443 clear
        add(0, 0, 5'h00, 0, 0, 0,   1, 4'b1000, 8'h8E, 0); // 444 offset 0

        reset = 1'b1; wr_en = 1'b0; wr_en_b = 1'b0; wr_addr = '0; wr_char = '0;
        wr_dp = 1'b0; scroll_en = 1'b0; scroll_clr = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b0;

        for (int i = 0; i < vq.size(); i++) begin
            wr_en = vq[i].wr_en; wr_addr = vq[i].addr; wr_char = vq[i].ch; wr_dp = vq[i].dp;
            scroll_en = vq[i].sen; scroll_clr = vq[i].sclr;
            repeat (vq[i].wait_cyc) @(negedge clock);
            check($sformatf("v%0d digit", i), {4'b0, digit}, {4'b0, vq[i].exp_digit});
            check($sformatf("v%0d seg", i), abcdefgh, vq[i].exp_seg);
            check($sformatf("v%0d frame_tick", i), {7'b0, frame_tick}, {7'b0, vq[i].exp_ft});
        end
        wr_en = 1'b0; scroll_en = 1'b0; scroll_clr = 1'b0;

        // Reset two cycles into a slot; buffer must come back blank.
        repeat (2) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("midrst digit", {4'b0, digit}, 8'h01);
        check("midrst seg", abcdefgh, 8'h00);
        check("midrst frame_tick", {7'b0, frame_tick}, 8'h00);
        repeat (3) @(negedge clock);
        check("midrst digit c3", {4'b0, digit}, 8'h01);
        @(negedge clock);
        check("midrst digit c4", {4'b0, digit}, 8'h02);
        repeat (8) @(negedge clock);
        check("midrst digit c12", {4'b0, digit}, 8'h08);
        check("midrst buf cleared", abcdefgh, 8'h00);

        // 6-entry instance: addresses 6 and 7 are out of range.
        wr_en_b = 1'b1; wr_addr = 3'd0; wr_char = 5'h01; wr_dp = 1'b1;
        @(negedge clock);
        wr_addr = 3'd6; wr_char = 5'h08;
        @(negedge clock);
        wr_addr = 3'd7;
        @(negedge clock);
        wr_en_b = 1'b0; wr_dp = 1'b0;
        repeat (13) @(negedge clock);
        check("oor d3 frame1", abcdefgh_b, 8'h61);
        check("oor digit frame1", {4'b0, digit_b}, 8'h08);
        repeat (4) @(negedge clock);
        check("oor d0", abcdefgh_b, 8'h00);
        repeat (4) @(negedge clock);
        check("oor d1", abcdefgh_b, 8'h00);
        repeat (4) @(negedge clock);
        check("oor d2", abcdefgh_b, 8'h00);
        repeat (4) @(negedge clock);
        check("oor d3 frame2", abcdefgh_b, 8'h61);
        check("oor digit frame2", {4'b0, digit_b}, 8'h08);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
